dmem_axi_bridge: RTL and testbench

Data-side bridge between the CPU memory stage (SRAM-like request) and a single-beat AXI master port.
- Generates d_stall for the hazard unit; d_stall holds the M/W stages until the transfer completes.
- Read data is returned in the one cycle where d_stall deasserts. Only one transfer is outstanding at a time.
- Address translation, exception gating and the constant AXI fields (id=0, len=0, burst=INCR, lock/cache/prot=0) are handled in the SoC wrapper.

---
 rtl/dmem_axi_bridge.sv | 181 ++++++++++++++++++
 tb/tb_dmem_axi_bridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axi_bridge.sv
// Data-side bridge: CPU memory-stage SRAM-style request to a single-beat AXI master.
// Optional macro DMEM_POSTED_WRITE_EN: stores complete before the B response (posted writes).
module dmem_axi_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_req_en,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              done_o,
    output logic              bus_err,
    output logic              d_stall,
    output logic [ADDR_W-1:0] araddr,
    output logic [2:0]        arsize,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [ADDR_W-1:0] awaddr,
    output logic [2:0]        awsize,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wlast,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready
);

    typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_reg;
    logic [1:0]        size_reg;
    logic [31:0]       wdata_reg;
    logic [3:0]        wstrb_reg;
    logic              aw_done;
    logic              w_done;
    logic              b_pending;

    logic aw_fire;
    logic w_fire;
    logic aw_all;
    logic w_all;
    logic accept;

    assign aw_fire = awvalid & awready;
    assign w_fire  = wvalid & wready;
    assign aw_all  = aw_done | aw_fire;
    assign w_all   = w_done | w_fire;
    // An outstanding posted B blocks new requests unless it retires this very cycle.
    assign accept  = (state == IDLE) & data_req_en & ~(b_pending & ~bvalid);

    assign d_stall = ((state == IDLE) & data_req_en) | ((state != IDLE) & (state != DONE));

    assign araddr = addr_reg;
    assign arsize = {1'b0, size_reg};
    assign awaddr = addr_reg;
    assign awsize = {1'b0, size_reg};
    assign wdata  = wdata_reg;
    assign wstrb  = wstrb_reg;
    assign wlast  = 1'b1;

`ifdef DMEM_POSTED_WRITE_EN
    assign bready = b_pending;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            addr_reg   <= '0;
            size_reg   <= '0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            data_rdata <= '0;
            done_o     <= 1'b0;
            bus_err    <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
            b_pending  <= 1'b0;
`else
            bready     <= 1'b0;
`endif
        end else begin
            done_o  <= 1'b0;
            bus_err <= 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
            if (b_pending && bvalid) begin
                b_pending <= 1'b0;
                bus_err   <= (bresp != 2'b00);
            end
`endif
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_reg  <= data_addr;
                        size_reg  <= data_size;
                        wdata_reg <= data_wdata;
                        wstrb_reg <= data_wen;
                        if (data_wen == 4'b0000) begin
                            state   <= RD_A;
                            arvalid <= 1'b1;
                        end else begin
                            state   <= WR;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                        end
                    end
                end
                RD_A: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_D;
                    end
                end
                RD_D: begin
                    if (rvalid) begin
                        rready     <= 1'b0;
                        data_rdata <= rdata;
                        bus_err    <= (rresp != 2'b00);
                        done_o     <= 1'b1;
                        state      <= DONE;
                    end
                end
                WR: begin
                    if (aw_fire) awvalid <= 1'b0;
                    if (w_fire)  wvalid  <= 1'b0;
                    if (aw_all && w_all) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
`ifdef DMEM_POSTED_WRITE_EN
                        b_pending <= 1'b1;
                        done_o    <= 1'b1;
                        state     <= DONE;
`else
                        bready <= 1'b1;
                        state  <= WR_B;
`endif
                    end else begin
                        aw_done <= aw_all;
                        w_done  <= w_all;
                    end
                end
                WR_B: begin
`ifdef DMEM_POSTED_WRITE_EN
                    state <= IDLE;
`else
                    if (bvalid) begin
                        bready  <= 1'b0;
                        bus_err <= (bresp != 2'b00);
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end
`endif
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifndef DMEM_POSTED_WRITE_EN
    assign b_pending = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_axi_bridge.sv
// Directed testbench for dmem_axi_bridge: cycle-exact checks of loads, stores, errors and reset.
module tb_dmem_axi_bridge;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              data_req_en = 1'b0;
    logic [3:0]        data_wen = '0;
    logic [ADDR_W-1:0] data_addr = '0;
    logic [1:0]        data_size = '0;
    logic [31:0]       data_wdata = '0;
    logic [31:0]       data_rdata;
    logic              done_o, bus_err, d_stall;
    logic [ADDR_W-1:0] araddr, awaddr;
    logic [2:0]        arsize, awsize;
    logic              arvalid, rready, awvalid, wvalid, wlast, bready;
    logic              arready = 1'b0, rvalid = 1'b0, awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
    logic [31:0]       rdata = '0;
    logic [1:0]        rresp = '0, bresp = '0;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;

    int checks = 0;
    int errors = 0;

    dmem_axi_bridge #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .data_req_en(data_req_en), .data_wen(data_wen), .data_addr(data_addr),
        .data_size(data_size), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .done_o(done_o), .bus_err(bus_err), .d_stall(d_stall),
        .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Zero-wait load with a reactive R channel; reports cycles from request to done_o.
    task automatic do_load(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                           output int cyc, output logic err, output logic [31:0] got);
        data_req_en = 1'b1; data_wen = 4'b0000; data_addr = a; data_size = 2'd2; arready = 1'b1;
        cyc = 0; err = 1'b0; got = '0;
        for (int i = 0; i < 20; i++) begin
            tick;
            cyc++;
            rvalid = rready; rdata = d; rresp = resp;
            if (done_o) begin
                err = bus_err;
                got = data_rdata;
                break;
            end
        end
        data_req_en = 1'b0; rvalid = 1'b0; arready = 1'b0; rresp = 2'b00;
        tick;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, done_o, bus_err, d_stall} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {arvalid, rready, awvalid, wvalid, bready, done_o, bus_err, d_stall});
        end
        checks++;
        if ({data_rdata, araddr, arsize, awaddr, wdata, wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h araddr=%h arsize=%b wdata=%h wstrb=%b want all 0",
                     data_rdata, araddr, arsize, wdata, wstrb);
        end
        data_req_en = 1'b1;
        #1;
        checks++;
        if (d_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_follows_req: got %b want 1", d_stall);
        end
        data_req_en = 1'b0;
        #1;
        rst = 1'b0;
        tick;
        $display("test_reset done");
    endtask

    task automatic test_load;
        data_req_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h1FC0_0010; data_size = 2'd2;
        arready = 1'b1;
        #1;
        checks++;
        if (d_stall !== 1'b1) begin errors++; $display("FAIL load_c1_stall: got %b want 1", d_stall); end
        tick;
        checks++;
        if ({arvalid, d_stall, done_o} !== 3'b110 || araddr !== 32'h1FC0_0010 || arsize !== 3'b010) begin
            errors++;
            $display("FAIL load_c2_ar: arvalid/stall/done=%b araddr=%h arsize=%b want 110 1fc00010 010",
                     {arvalid, d_stall, done_o}, araddr, arsize);
        end
        tick;
        checks++;
        if ({arvalid, rready, d_stall, done_o} !== 4'b0110) begin
            errors++;
            $display("FAIL load_c3_r: ar/r/stall/done=%b want 0110", {arvalid, rready, d_stall, done_o});
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick;
        checks++;
        if ({done_o, d_stall, bus_err, rready} !== 4'b1000 || data_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_c4_done: done/stall/err/rready=%b rdata=%h want 1000 deadbeef",
                     {done_o, d_stall, bus_err, rready}, data_rdata);
        end
        rvalid = 1'b0; data_req_en = 1'b0; arready = 1'b0;
        tick;
        checks++;
        if ({done_o, d_stall, arvalid} !== 3'b000) begin
            errors++;
            $display("FAIL load_c5_idle: done/stall/arvalid=%b want 000", {done_o, d_stall, arvalid});
        end
        $display("test_load done");
    endtask

`ifndef DMEM_POSTED_WRITE_EN
    task automatic test_store;
        data_req_en = 1'b1; data_wen = 4'b1000; data_addr = 32'h0000_0003; data_size = 2'd0;
        data_wdata = 32'hAB00_0000; awready = 1'b0; wready = 1'b1;
        tick;
        checks++;
        if ({awvalid, wvalid, bready, d_stall} !== 4'b1101 || awaddr !== 32'h3 || awsize !== 3'b000
            || wstrb !== 4'b1000 || wdata !== 32'hAB00_0000 || wlast !== 1'b1) begin
            errors++;
            $display("FAIL store_c1: aw/w/b/stall=%b awaddr=%h awsize=%b wstrb=%b wdata=%h want 1101 3 000 1000 ab000000",
                     {awvalid, wvalid, bready, d_stall}, awaddr, awsize, wstrb, wdata);
        end
        tick;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            errors++;
            $display("FAIL store_c2: aw/w/b=%b want 100", {awvalid, wvalid, bready});
        end
        tick;
        checks++;
        if ({awvalid, wvalid, bready} !== 3'b100) begin
            errors++;
            $display("FAIL store_c3: aw/w/b=%b want 100", {awvalid, wvalid, bready});
        end
        awready = 1'b1;
        tick;
        checks++;
        if ({awvalid, wvalid, bready, d_stall, done_o} !== 5'b00110) begin
            errors++;
            $display("FAIL store_wr_b: aw/w/b/stall/done=%b want 00110", {awvalid, wvalid, bready, d_stall, done_o});
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick;
        checks++;
        if ({done_o, bus_err, bready, d_stall} !== 4'b1000) begin
            errors++;
            $display("FAIL store_done: done/err/b/stall=%b want 1000", {done_o, bus_err, bready, d_stall});
        end
        bvalid = 1'b0; data_req_en = 1'b0; data_wen = 4'b0000;
        tick;
        $display("test_store done");
    endtask
`endif

    task automatic test_back_to_back;
        int ar_cnt = 0;
        int dn = 0;
        data_req_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_2000; data_size = 2'd2; arready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (arvalid && arready) ar_cnt++;
            rvalid = rready; rdata = 32'h0000_1000 + dn; rresp = 2'b00;
            if (done_o) begin
                checks++;
                if (data_rdata !== 32'h0000_1000 + dn) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h want %h", dn, data_rdata, 32'h0000_1000 + dn);
                end
                dn++;
                if (dn == 2) data_req_en = 1'b0;
            end
        end
        arready = 1'b0; rvalid = 1'b0;
        checks++;
        if (ar_cnt !== 2 || dn !== 2) begin
            errors++;
            $display("FAIL b2b_counts: ar_handshakes=%0d dones=%0d want 2 2", ar_cnt, dn);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_bus_err;
        int cyc;
        logic err;
        logic [31:0] got;
        do_load(32'h0000_0100, 32'h1234_5678, 2'b10, cyc, err, got);
        checks++;
        if (cyc !== 3 || err !== 1'b1) begin
            errors++;
            $display("FAIL rresp_err: cycles=%0d bus_err=%b want 3 1", cyc, err);
        end
        do_load(32'h0000_0104, 32'hCAFE_F00D, 2'b00, cyc, err, got);
        checks++;
        if (cyc !== 3 || err !== 1'b0 || got !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL after_err_load: cycles=%0d bus_err=%b data=%h want 3 0 cafef00d", cyc, err, got);
        end
        $display("test_bus_err done");
    endtask

    task automatic test_reset_mid;
        data_req_en = 1'b1; data_wen = 4'b0000; data_addr = 32'h0000_0300; data_size = 2'd2; arready = 1'b1;
        tick; tick;
        checks++;
        if ({arvalid, rready} !== 2'b01) begin
            errors++;
            $display("FAIL rmid_in_rd_d: ar/r=%b want 01", {arvalid, rready});
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({arvalid, rready, awvalid, wvalid, bready, done_o, bus_err} !== 7'b0 || d_stall !== 1'b1) begin
            errors++;
            $display("FAIL rmid_async: ctrl=%b stall=%b want 0000000 1",
                     {arvalid, rready, awvalid, wvalid, bready, done_o, bus_err}, d_stall);
        end
        data_req_en = 1'b0;
        #1;
        checks++;
        if (d_stall !== 1'b0) begin errors++; $display("FAIL rmid_stall_req0: got %b want 0", d_stall); end
        tick;
        rst = 1'b0; arready = 1'b0; rvalid = 1'b1; rdata = 32'hBAD0_BAD0;
        tick;
        checks++;
        if ({arvalid, rready, done_o, d_stall} !== 4'b0000 || data_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rmid_after: ar/r/done/stall=%b rdata=%h want 0000 0",
                     {arvalid, rready, done_o, d_stall}, data_rdata);
        end
        rvalid = 1'b0;
        tick;
        $display("test_reset_mid done");
    endtask

`ifdef DMEM_POSTED_WRITE_EN
    task automatic test_posted;
        data_req_en = 1'b1; data_wen = 4'b1111; data_addr = 32'h0000_0040; data_size = 2'd2;
        data_wdata = 32'h1122_3344; awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        tick;
        checks++;
        if ({awvalid, wvalid, d_stall} !== 3'b111) begin
            errors++;
            $display("FAIL posted_wr: aw/w/stall=%b want 111", {awvalid, wvalid, d_stall});
        end
        tick;
        checks++;
        if ({done_o, d_stall, bready, awvalid, wvalid} !== 5'b10100) begin
            errors++;
            $display("FAIL posted_done: done/stall/b/aw/w=%b want 10100", {done_o, d_stall, bready, awvalid, wvalid});
        end
        awready = 1'b0; wready = 1'b0;
        data_wen = 4'b0000; data_addr = 32'h0000_0080; arready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            checks++;
            if ({arvalid, d_stall, bready} !== 3'b011) begin
                errors++;
                $display("FAIL posted_block%0d: ar/stall/b=%b want 011", i, {arvalid, d_stall, bready});
            end
        end
        bvalid = 1'b1; bresp = 2'b00;
        tick;
        checks++;
        if ({arvalid, bready} !== 2'b10 || araddr !== 32'h0000_0080) begin
            errors++;
            $display("FAIL posted_ar_after_b: ar/b=%b araddr=%h want 10 80", {arvalid, bready}, araddr);
        end
        bvalid = 1'b0;
        tick;
        rvalid = 1'b1; rdata = 32'h0000_0055;
        tick;
        checks++;
        if (done_o !== 1'b1 || data_rdata !== 32'h0000_0055) begin
            errors++;
            $display("FAIL posted_load_done: done=%b rdata=%h want 1 55", done_o, data_rdata);
        end
        rvalid = 1'b0; data_req_en = 1'b0; arready = 1'b0;
        tick;
        $display("test_posted done");
    endtask
`endif

    initial begin
        test_reset;
        test_load;
`ifndef DMEM_POSTED_WRITE_EN
        test_store;
`endif
        test_back_to_back;
        test_bus_err;
        test_reset_mid;
`ifdef DMEM_POSTED_WRITE_EN
        test_posted;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
